mips_regfile: RTL and testbench
===============================

// Module: mips_regfile
//
// PURPOSE
//   Register file stage directly upstream of the 32-bit ALU in the single-cycle MIPS datapath.
//   Provides two asynchronous read ports, which drive ALU operands A and B (B via the ALUSrc mux).
//   Provides one synchronous write port, loaded from the writeback mux (ALU R or memory data).
//   Register $0 is hardwired to zero. All storage clears on asynchronous active-low reset.
//
// PARAMETERS
//   DATA_W   32   width of each register and of the read/write data ports
//   ADDR_W   5    register index width
//   NREGS    32   number of registers; must equal 2**ADDR_W
//
// PORTS
//   clk          in   1        single clock; all writes occur on its rising edge
//   rst_n        in   1        asynchronous active-low reset
//   read_reg1    in   ADDR_W   read port 1 index (instr rs)
//   read_reg2    in   ADDR_W   read port 2 index (instr rt)
//   write_reg    in   ADDR_W   write index (rt or rd, from RegDst mux)
//   write_data   in   DATA_W   writeback value
//   reg_write    in   1        write enable (RegWrite from main control)
//   read_data1   out  DATA_W   contents of read_reg1 (to ALU A)
//   read_data2   out  DATA_W   contents of read_reg2 (to ALU B / mem write data)
//
// BEHAVIOUR
//   - Reset: rst_n=0 clears all NREGS registers to 0 immediately, without waiting for clk.
//     * read_data1/2 read 0 while reset is held.
//     * Reset wins over a coincident write edge.
//     * Deasserting reset mid-cycle takes effect on the next rising edge.
//   - Write: on posedge clk with rst_n=1 and reg_write=1, regs[write_reg] <= write_data.
//     * Latency is 1 edge.
//     * reg_write=0 means no register changes.
//   - $0: a write with write_reg=0 is discarded. regs[0] reads 0 at all times.
//   - Read: read_dataN = regs[read_regN] combinationally (0-cycle latency, no clock).
//     * Both ports may address the same register; both return the same value.
//   - Read-during-write (same index, same cycle):
//     * Default: the read returns the pre-edge (old) value until the edge.
//     * Bypass: see CONFIGURATION.
//   - Widths:
//     * write_data is stored unmodified; no sign or zero handling in this block.
//     * Indices are full range 0..NREGS-1, so there are no out-of-range cases.
//   - X handling: if reg_write is X, the bench flags an error.
//     * The RTL does not guard against X on reg_write.
//     * When reg_write=0, X on the write index or data must not corrupt storage.
//   - Structure:
//     * Per-register DATA_W D flip-flops with async clear.
//     * 5:32 write decoder ANDed with reg_write; decoder output 0 is tied off.
//     * Two 32:1 DATA_W read muxes.
//
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     * Write-through applies when reg_write=1, write_reg!=0 and read_regN==write_reg.
//     * In that case read_dataN = write_data combinationally in the same cycle.
//     * This allows a consumer to see the value before the edge.
//     * A read of $0 still returns 0.
//   REGFILE_BYPASS_EN undefined:
//     * No forwarding mux; reads reflect stored state only.
//
// TESTING
//   1 Reset: write 0xDEADBEEF to r5, assert rst_n=0 mid-cycle
//       -> read_data1 (reg 5) = 0 within the same cycle, before any clk edge.
//   2 Write/read: reg_write=1, write_reg=8, write_data=0x00000007, then 1 edge
//       -> read_reg1=8 gives 7, and read_reg2=8 also gives 7.
//   3 $0 protect: reg_write=1, write_reg=0, write_data=0xFFFFFFFF, then edge
//       -> read_reg1=0 gives 0x00000000.
//   4 Write disable: r9=0x12345678, then reg_write=0, write_reg=9, write_data=0, then edge
//       -> r9 still reads 0x12345678.
//   5 Read-during-write: r3=0x11, then drive write_reg=3, write_data=0x22, reg_write=1, read_reg2=3.
//       Before the edge:
//       -> reads 0x11 (bypass undefined)
//       -> reads 0x22 (REGFILE_BYPASS_EN defined)
//       After the edge -> 0x22 in both builds.
//   6 Full sweep: write r(i)=i*0x01010101 for i=1..31, then read all pairs (i, 31-i)
//       -> each port returns its own pattern, and r0 returns 0.

Source files
------------

// File: rtl/mips_regfile.sv
// mips_regfile: 32 x 32-bit MIPS register file.
//   Two combinational read ports, one rising-edge write port, $0 hardwired to 0.
//   All storage clears immediately on asynchronous active-low reset.
//   Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a read of the
//   register being written in the same cycle returns write_data before the edge.
module mips_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  wr_en;

    // Write decoder: one-hot enable per register, gated by reg_write; entry 0 is tied off
    always_comb begin
        wr_en = '0;
        for (int i = 1; i < NREGS; i++) begin
            wr_en[i] = reg_write && (write_reg == ADDR_W'(i));
        end
    end

    // Next-state for each register: hold unless its decoder line is active
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en[i]) begin
                regs_d[i] = write_data;
            end
        end
        // $0 never holds anything but zero
        regs_d[0] = '0;
    end

    // Storage flops with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic byp1;
    logic byp2;

    // Write-through detect; qualified by rst_n so reads stay 0 while reset is held
    always_comb begin
        byp1 = rst_n && reg_write && (write_reg != '0) && (read_reg1 == write_reg);
        byp2 = rst_n && reg_write && (write_reg != '0) && (read_reg2 == write_reg);
    end

    // Read muxes with forwarding of the in-flight write value
    always_comb begin
        read_data1 = regs_q[read_reg1];
        read_data2 = regs_q[read_reg2];
        if (byp1) begin
            read_data1 = write_data;
        end
        if (byp2) begin
            read_data2 = write_data;
        end
    end
`else
    // Read muxes reflecting stored state only
    always_comb begin
        read_data1 = regs_q[read_reg1];
        read_data2 = regs_q[read_reg2];
    end
`endif

endmodule

// File: tb/tb_mips_regfile.sv
// tb_mips_regfile: directed + random checks of mips_regfile against an array model.
module tb_mips_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int errors = 0;
    int checks = 0;

    // Reference storage: what each architectural register should hold
    logic [31:0] model [32];

    mips_regfile #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .reg_write  (reg_write),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    // Clock: posedges at 5, 15, 25 ...; inputs change on negedges
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected read value given the model and the currently driven write port
    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (rst_n !== 1'b1) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (reg_write === 1'b1 && write_reg === idx) return write_data;
`endif
        return model[idx];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        #1;
        check({tag, ".rd1"}, read_data1, model_read(read_reg1));
        check({tag, ".rd2"}, read_data2, model_read(read_reg2));
    endtask

    // One rising edge; the model commits the write the DUT should perform, then back to negedge
    task automatic tick();
        @(posedge clk);
        if (reg_write === 1'bx || reg_write === 1'bz) begin
            checks++;
            errors++;
            $error("FAIL reg_write_x got=%b expected=0or1", reg_write);
        end
        if (rst_n === 1'b1 && reg_write === 1'b1 && write_reg != 5'd0)
            model[write_reg] = write_data;
        @(negedge clk);
    endtask

    task automatic drive_write(input logic [4:0] wr, input logic [31:0] d, input logic we);
        write_reg  = wr;
        write_data = d;
        reg_write  = we;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst_n = 1'b0;
        read_reg1 = '0;
        read_reg2 = '0;
        drive_write(5'd0, 32'h0, 1'b0);

        // Reset held: all reads zero
        @(negedge clk);
        read_reg1 = 5'd1; read_reg2 = 5'd31;
        check_ports("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i += 8) begin
            read_reg1 = 5'(i); read_reg2 = 5'(i + 7);
            check_ports("post_reset");
        end

        // 1: async reset clears r5 mid-cycle, and wins over a coincident write edge
        drive_write(5'd5, 32'hDEADBEEF, 1'b1);
        tick();
        drive_write(5'd0, 32'h0, 1'b0);
        read_reg1 = 5'd5; read_reg2 = 5'd5;
        check_ports("r5_written");
        #2 rst_n = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1 check("reset_async", read_data1, 32'h0);
        @(negedge clk);
        drive_write(5'd5, 32'hCAFEF00D, 1'b1);
        tick();
        drive_write(5'd0, 32'h0, 1'b0);
        check_ports("reset_wins");
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_ports("reset_release");

        // 2: write/read on both ports
        drive_write(5'd8, 32'h00000007, 1'b1);
        tick();
        drive_write(5'd0, 32'h0, 1'b0);
        read_reg1 = 5'd8; read_reg2 = 5'd8;
        check_ports("wr_r8");
        check("wr_r8_const", read_data2, 32'h7);

        // 3: $0 write is discarded
        drive_write(5'd0, 32'hFFFFFFFF, 1'b1);
        read_reg1 = 5'd0; read_reg2 = 5'd0;
        check_ports("r0_during");
        tick();
        check("r0_protect", read_data1, 32'h0);

        // 4: write disable, also with X index/data
        drive_write(5'd9, 32'h12345678, 1'b1);
        tick();
        drive_write(5'd9, 32'h0, 1'b0);
        read_reg1 = 5'd9; read_reg2 = 5'd8;
        tick();
        check("we0_r9", read_data1, 32'h12345678);
        check_ports("we0");
        write_reg = 5'bx; write_data = 32'bx; reg_write = 1'b0;
        tick();
        drive_write(5'd0, 32'h0, 1'b0);
        check_ports("we0_xaddr");

        // 5: read during write
        drive_write(5'd3, 32'h11, 1'b1);
        tick();
        drive_write(5'd3, 32'h22, 1'b1);
        read_reg1 = 5'd0; read_reg2 = 5'd3;
`ifdef REGFILE_BYPASS_EN
        #1 check("rdw_before", read_data2, 32'h22);
`else
        #1 check("rdw_before", read_data2, 32'h11);
`endif
        check_ports("rdw_before_m");
        tick();
        check("rdw_after", read_data2, 32'h22);
        drive_write(5'd0, 32'h0, 1'b0);

        // 6: full sweep of distinct patterns
        for (int i = 1; i < 32; i++) begin
            drive_write(5'(i), 32'(i) * 32'h01010101, 1'b1);
            tick();
        end
        drive_write(5'd0, 32'h0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i); read_reg2 = 5'(31 - i);
            #1;
            check("sweep.rd1", read_data1, (i == 0) ? 32'h0 : 32'(i) * 32'h01010101);
            check("sweep.rd2", read_data2, (i == 31) ? 32'h0 : 32'(31 - i) * 32'h01010101);
        end
        @(negedge clk);

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            drive_write(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
            read_reg1 = 5'($urandom_range(0, 31));
            read_reg2 = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
            check_ports("rand_pre");
            tick();
            check_ports("rand_post");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
